// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Shift-add multiply and restoring divide on operand magnitudes, one bit per
// cycle over 32 cycles. Divide-by-zero and signed overflow resolve at once.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic            wb_en,
  output logic [4:0]      rd_out,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t state, next_state;

  logic [5:0]        cnt;
  logic [2:0]        func;
  logic              sign_a, sign_b;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] acc;
  logic [XLEN:0]     rem;
  logic [XLEN-1:0]   quo;
  logic [4:0]        rd_q;

  logic              sa, sb, is_div, is_rem, div_by_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res, a_mag_c, b_mag_c;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] acc_nxt, prod;
  logic [XLEN+1:0]   div_shift, div_diff;
  logic [XLEN:0]     rem_nxt;
  logic [XLEN-1:0]   quo_nxt, final_res;
  logic              last_iter;

  // Decode operand signedness and the early-out cases from the live inputs.
  always_comb begin
    sa = (funct3 == 3'b001) || (funct3 == 3'b010) ||
         (funct3 == 3'b100) || (funct3 == 3'b110);
    sb = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    is_div = funct3[2];
    is_rem = funct3[1];
    a_mag_c = (sa && op_a[XLEN-1]) ? -op_a : op_a;
    b_mag_c = (sb && op_b[XLEN-1]) ? -op_b : op_b;
    div_by_zero = is_div && (op_b == '0);
    div_ovf = is_div && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) &&
              (op_b == '1);
    special = div_by_zero || div_ovf;
    if (div_by_zero)
      special_res = is_rem ? op_a : '1;
    else
      special_res = is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // One multiply step and one restoring-divide step, plus the signed fix-up.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_mag} : '0);
    acc_nxt   = {mul_sum, acc[XLEN-1:1]};
    div_shift = {rem, quo[XLEN-1]};
    div_diff  = div_shift - {2'b00, b_mag};
    rem_nxt   = div_diff[XLEN+1] ? div_shift[XLEN:0] : div_diff[XLEN:0];
    quo_nxt   = {quo[XLEN-2:0], ~div_diff[XLEN+1]};
    prod      = (sign_a ^ sign_b) ? -acc_nxt : acc_nxt;
    if (!func[2])
      final_res = (func[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (!func[1])
      final_res = (sign_a ^ sign_b) ? -quo_nxt : quo_nxt;
    else
      final_res = sign_a ? -rem_nxt[XLEN-1:0] : rem_nxt[XLEN-1:0];
    last_iter = (cnt == 6'd31);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic: IDLE -> CALC (or FIN on an early-out) -> FIN -> IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = special ? FIN : CALC;
      CALC:    if (last_iter) next_state = FIN;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand capture, iteration and result/write-back registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      func   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      a_mag  <= '0;
      b_mag  <= '0;
      acc    <= '0;
      rem    <= '0;
      quo    <= '0;
      rd_q   <= '0;
      rd_out <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= (next_state == FIN);
      case (state)
        IDLE: begin
          if (start) begin
            func   <= funct3;
            sign_a <= sa && op_a[XLEN-1];
            sign_b <= sb && op_b[XLEN-1];
            a_mag  <= a_mag_c;
            b_mag  <= b_mag_c;
            cnt    <= '0;
            acc    <= {{XLEN{1'b0}}, b_mag_c};
            rem    <= '0;
            quo    <= a_mag_c;
            rd_q   <= rd_in;
            if (special) begin
              result <= special_res;
              rd_out <= rd_in;
            end
          end
        end
        CALC: begin
          cnt <= cnt + 6'd1;
          acc <= acc_nxt;
          rem <= rem_nxt;
          quo <= quo_nxt;
          if (last_iter) begin
            result <= final_res;
            rd_out <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign wb_en = done;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with hand-computed results for muldiv_unit.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        busy, done, wb_en;
  logic [4:0]  rd_out;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .busy(busy), .done(done),
    .wb_en(wb_en), .rd_out(rd_out), .result(result)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
    end
  endtask

  // Present a request for one edge; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Latency in cycles from start to done (1 = done right after accept), -1 on timeout.
  task automatic waitDone(output int lat);
    bit seen;
    lat = -1;
    seen = 1'b0;
    if (done) begin
      lat = 1;
      seen = 1'b1;
    end
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i + 1;
        seen = 1'b1;
      end
    end
  endtask

  // Complete operation: issue, wait, check result/rd/strobe, check strobe ends.
  task automatic runOp(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] expRes, input int expLat);
    int lat;
    applyStimulus(f, a, b, rd);
    waitDone(lat);
    checkOutput({tag, "_lat"}, lat, expLat);
    checkOutput({tag, "_res"}, result, expRes);
    checkOutput({tag, "_rd"}, {27'd0, rd_out}, {27'd0, rd});
    checkOutput({tag, "_wb"}, {31'd0, wb_en}, 32'd1);
    @(posedge clk); #1;
    checkOutput({tag, "_doneoff"}, {30'd0, done, wb_en}, 32'd0);
    checkOutput({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int early;
    int wbSeen;
    rst_n = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {30'd0, done, wb_en}, 32'd0);
    checkOutput("rst_rd", {27'd0, rd_out}, 32'd0);
    checkOutput("rst_res", result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    runOp("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33);
    runOp("mulh",   3'b001, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 33);
    runOp("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 33);
    runOp("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 33);
    runOp("div",    3'b100, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 33);
    runOp("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 33);
    runOp("divu",   3'b101, 32'd100,      32'd7,        5'd11, 32'd14,       33);
    runOp("remu",   3'b111, 32'd100,      32'd7,        5'd12, 32'd2,        33);
    runOp("divu0",  3'b101, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1);
    runOp("rem0",   3'b110, 32'd5,        32'd0,        5'd14, 32'd5,        1);
    runOp("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1);
    runOp("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        1);
    runOp("mulz",   3'b000, 32'd0,        32'd1234,     5'd17, 32'd0,        33);

    // Starts while busy (mid-CALC and during FIN) must be dropped.
    applyStimulus(3'b000, 32'd6, 32'd7, 5'd9);
    early = 0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (i == 5) begin
        start = 1'b1; funct3 = 3'b101; op_a = 32'd5; op_b = 32'd0; rd_in = 5'd1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (i < 32 && done) early++;
    end
    checkOutput("ign_early", early, 32'd0);
    checkOutput("ign_done", {31'd0, done}, 32'd1);
    checkOutput("ign_res", result, 32'd42);
    checkOutput("ign_rd", {27'd0, rd_out}, 32'd9);
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd3;
    @(posedge clk); #1;
    checkOutput("ign_fin_busy", {31'd0, busy}, 32'd0);
    checkOutput("ign_hold_res", result, 32'd42);
    checkOutput("ign_hold_rd", {27'd0, rd_out}, 32'd9);
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("next_busy", {31'd0, busy}, 32'd1);
    waitDone(lat);
    checkOutput("next_lat", lat, 32'd33);
    checkOutput("next_res", result, 32'd14);
    checkOutput("next_rd", {27'd0, rd_out}, 32'd3);
    @(posedge clk); #1;

    // Reset in the middle of a divide aborts it with no write-back.
    applyStimulus(3'b100, 32'd100, 32'd7, 5'd12);
    repeat (10) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", {31'd0, busy}, 32'd0);
    checkOutput("arst_done", {30'd0, done, wb_en}, 32'd0);
    checkOutput("arst_res", result, 32'd0);
    checkOutput("arst_rd", {27'd0, rd_out}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wbSeen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (wb_en) wbSeen++;
    end
    checkOutput("arst_nowb", wbSeen, 32'd0);
    runOp("postrst", 3'b000, 32'd3, 32'd4, 5'd7, 32'd12, 33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
